// File: rtl/mpu_host_memory.sv
// MPU host-memory read responder: one 64-bit load as two
// Wishbone classic 32-bit read beats, low word first.
module mpu_host_memory #(
  parameter int TIMEOUT = 256
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        hm_start,
  input  logic [63:0] hm_addr,
  output logic [63:0] hm_data,
  output logic        hm_end,
  output logic        hm_error,
  output logic        hm_busy,
  output logic [31:0] wb_adr_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    END
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   base_q, base_d;
  logic [63:0]   data_q, data_d;
  logic          err_q, err_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          active;
  logic          unused_addr;

  // quad-word aligned: the byte offset bits never reach the bus
  assign unused_addr = ^hm_addr[2:0];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      data_q  <= data_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    data_d  = data_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      IDLE: begin
        if (hm_start) begin
          err_d = 1'b0;
          if (hm_addr[63:32] == 32'd0) begin
            base_d  = {hm_addr[31:3], 3'b000};
            tmo_d   = '0;
            state_d = LO;
          end else begin
            err_d   = 1'b1;
            data_d  = '0;
            state_d = END;
          end
        end
      end
      LO, HI: begin
        // err wins over a simultaneous ack
        if (wb_err_i || (!wb_ack_i && tmo_q == TMAX)) begin
          err_d   = 1'b1;
          data_d  = '0;
          state_d = END;
        end else if (wb_ack_i) begin
          tmo_d = '0;
          if (state_q == LO) begin
            data_d[31:0] = wb_dat_i;
            state_d      = HI;
          end else begin
            data_d[63:32] = wb_dat_i;
            state_d       = END;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      END: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign active   = (state_q == LO) || (state_q == HI);
  assign wb_cyc_o = active;
  assign wb_stb_o = active;
  assign wb_we_o  = 1'b0;
  assign wb_sel_o = active ? 4'hF : 4'h0;
  assign wb_adr_o = (state_q == HI) ? base_q + 32'd4 :
                    (state_q == LO) ? base_q : 32'd0;
  assign hm_data  = data_q;
  assign hm_error = err_q;
  assign hm_end   = (state_q == END);
  assign hm_busy  = (state_q != IDLE);

endmodule
